// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and next-PC select encoding for the fetch PC unit
package pc_pkg;

    localparam int INSTR_BYTES = 4;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

    typedef enum logic [2:0] {
        NPC_RESET,
        NPC_EXC,
        NPC_ERET,
        NPC_REDIR,
        NPC_HOLD,
        NPC_SEQ
    } npc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with saturating count
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             pop,
    output logic [WIDTH-1:0] top,
    output logic             valid
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] entries [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic [PTR_W-1:0] ptr_inc;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RAS_DEPTH));
    // Depth is a power of two, so the pointer wraps naturally.
    assign ptr_inc = top_ptr + PTR_W'(1);

    // Entry write port: a push+pop on a non-empty stack replaces the top in place,
    // any other push lands one slot above the current top (overwriting the oldest when full).
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = ptr_inc;
        if (!reset && !clear && push) begin
            wr_en  = 1'b1;
            wr_idx = (pop && !empty) ? top_ptr : ptr_inc;
        end
    end

    // Entry storage has no reset; the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entries[wr_idx] <= push_addr;
        end
    end

    // Pointer and count update; clear only empties the stack and leaves the pointer alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push && pop && !empty) begin
            top_ptr <= top_ptr;
        end else if (push) begin
            top_ptr <= ptr_inc;
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            top_ptr <= top_ptr - PTR_W'(1);
            count   <= count - CNT_W'(1);
        end
    end

    assign valid = !empty;
    assign top   = empty ? '0 : entries[top_ptr];

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with prioritised next-PC select, EPC and RAS
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             exc_valid,
    input  logic [WIDTH-1:0] exc_pc,
    input  logic             eret,
    input  logic             ras_push,
    input  logic [WIDTH-1:0] ras_push_addr,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] pc_out,
    output logic             pc_misaligned,
    output logic [WIDTH-1:0] epc_out,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_valid
);

    npc_sel_e         npc_sel;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_q;
    logic             misaligned_q;
    logic [WIDTH-1:0] epc_q;

    // Priority select: reset, exception, eret, redirect, stall, then sequential.
    always_comb begin
        npc_sel = NPC_SEQ;
        if (reset) begin
            npc_sel = NPC_RESET;
        end else if (exc_valid) begin
            npc_sel = NPC_EXC;
        end else if (eret) begin
            npc_sel = NPC_ERET;
        end else if (redirect_valid) begin
            npc_sel = NPC_REDIR;
        end else if (stall) begin
            npc_sel = NPC_HOLD;
        end
    end

    // Next-PC mux; targets are loaded unchanged even when misaligned.
    always_comb begin
        pc_next = pc_q + WIDTH'(INSTR_BYTES);
        case (npc_sel)
            NPC_RESET: pc_next = RESET_VECTOR;
            NPC_EXC:   pc_next = EXC_VECTOR;
            NPC_ERET:  pc_next = epc_q;
            NPC_REDIR: pc_next = redirect_target;
            NPC_HOLD:  pc_next = pc_q;
            NPC_SEQ:   pc_next = pc_q + WIDTH'(INSTR_BYTES);
            default:   pc_next = pc_q + WIDTH'(INSTR_BYTES);
        endcase
    end

    // PC and its alignment flag are registered together so they always describe the same fetch.
    always_ff @(posedge clk) begin
        pc_q         <= pc_next;
        misaligned_q <= (pc_next[1:0] != 2'b00);
    end

    // EPC changes only when an exception is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            epc_q <= '0;
        end else if (exc_valid) begin
            epc_q <= exc_pc;
        end
    end

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .clear     (exc_valid),
        .push      (ras_push),
        .push_addr (ras_push_addr),
        .pop       (ras_pop),
        .top       (ras_top),
        .valid     (ras_valid)
    );

    assign pc_out        = pc_q;
    assign pc_misaligned = misaligned_q;
    assign epc_out       = epc_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit against a queue-based reference model
module tb_pc_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, exc_valid, eret, ras_push, ras_pop;
    logic [31:0] redirect_target, exc_pc, ras_push_addr;
    logic [31:0] pc_out, epc_out, ras_top;
    logic        pc_misaligned, ras_valid;

    logic        reset8, redirect_valid8, ras_push8;
    logic [7:0]  redirect_target8, ras_push_addr8;
    logic [7:0]  pc_out8, epc_out8, ras_top8;
    logic        pc_misaligned8, ras_valid8;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_pc, m_epc;
    logic [31:0] ras_q[$];

    always #5 clk = ~clk;

    pc_unit #(.WIDTH(32), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .eret(eret),
        .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
        .pc_out(pc_out), .pc_misaligned(pc_misaligned), .epc_out(epc_out),
        .ras_top(ras_top), .ras_valid(ras_valid)
    );

    pc_unit #(.WIDTH(8), .RESET_VECTOR(8'h00), .EXC_VECTOR(8'h80), .RAS_DEPTH(DEPTH)) dut8 (
        .clk(clk), .reset(reset8), .stall(1'b0),
        .redirect_valid(redirect_valid8), .redirect_target(redirect_target8),
        .exc_valid(1'b0), .exc_pc(8'h00), .eret(1'b0),
        .ras_push(ras_push8), .ras_push_addr(ras_push_addr8), .ras_pop(1'b0),
        .pc_out(pc_out8), .pc_misaligned(pc_misaligned8), .epc_out(epc_out8),
        .ras_top(ras_top8), .ras_valid(ras_valid8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; exc_valid = 1'b0; eret = 1'b0;
        ras_push = 1'b0; ras_pop = 1'b0;
        redirect_target = '0; exc_pc = '0; ras_push_addr = '0;
    endtask

    // Reference behaviour for one clock edge, written from the architectural rules.
    task automatic model_edge();
        logic [31:0] old_epc;
        old_epc = m_epc;
        if (reset) begin
            m_pc  = 32'h0;
            m_epc = 32'h0;
            ras_q.delete();
        end else begin
            if (exc_valid) begin
                m_pc  = 32'h80;
                m_epc = exc_pc;
                ras_q.delete();
            end else begin
                if (eret)                m_pc = old_epc;
                else if (redirect_valid) m_pc = redirect_target;
                else if (!stall)         m_pc = m_pc + 32'd4;
                if (ras_push && ras_pop && ras_q.size() > 0) begin
                    ras_q[ras_q.size()-1] = ras_push_addr;
                end else if (ras_push) begin
                    ras_q.push_back(ras_push_addr);
                    if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
                end else if (ras_pop && ras_q.size() > 0) begin
                    void'(ras_q.pop_back());
                end
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        model_edge();
        chk({tag, ".pc"}, pc_out, m_pc);
        chk({tag, ".mis"}, {31'b0, pc_misaligned}, {31'b0, m_pc[1:0] != 2'b00});
        chk({tag, ".epc"}, epc_out, m_epc);
        chk({tag, ".rvalid"}, {31'b0, ras_valid}, {31'b0, ras_q.size() != 0});
        chk({tag, ".rtop"}, ras_top, (ras_q.size() != 0) ? ras_q[ras_q.size()-1] : 32'h0);
    endtask

    initial begin
        idle();
        reset8 = 1'b1; redirect_valid8 = 1'b0; redirect_target8 = '0;
        ras_push8 = 1'b0; ras_push_addr8 = '0;
        m_pc = '0; m_epc = '0;

        reset = 1'b1;
        step("reset");
        chk("reset_pc", pc_out, 32'h0);
        chk("reset_valid", {31'b0, ras_valid}, 32'h0);
        idle();
        step("run1"); step("run2"); step("run3");
        chk("run_pc_c", pc_out, 32'hC);
        step("run4");

        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
        step("stall_redir");
        idle(); stall = 1'b1;
        step("stall1"); step("stall2");
        chk("stall_hold", pc_out, 32'h200);

        idle(); exc_valid = 1'b1; exc_pc = 32'h44; eret = 1'b1;
        step("exc_eret");
        chk("exc_pc_vec", pc_out, 32'h80);
        chk("exc_epc", epc_out, 32'h44);
        idle(); step("after_exc");
        eret = 1'b1; step("eret");
        chk("eret_pc", pc_out, 32'h44);
        idle(); step("after_eret");
        chk("after_eret_pc", pc_out, 32'h48);

        redirect_valid = 1'b1; redirect_target = 32'h102;
        step("misalign");
        chk("misalign_flag", {31'b0, pc_misaligned}, 32'h1);
        idle(); step("misalign_seq");
        chk("misalign_seq_pc", pc_out, 32'h106);
        redirect_valid = 1'b1; redirect_target = 32'h300;
        step("realign");
        chk("realign_flag", {31'b0, pc_misaligned}, 32'h0);

        idle(); stall = 1'b1; ras_push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ras_push_addr = 32'hA000 + 32'(i) * 32'h10;
            step("push");
        end
        chk("push_top_e", ras_top, 32'hA040);
        idle(); ras_pop = 1'b1;
        for (int i = 0; i < 5; i++) step("pop");
        chk("pop_empty_top", ras_top, 32'h0);
        chk("pop_empty_valid", {31'b0, ras_valid}, 32'h0);
        idle(); ras_push = 1'b1; ras_push_addr = 32'hB000; step("push_g");
        ras_pop = 1'b1; ras_push_addr = 32'hF000; step("pushpop_f");
        chk("pushpop_top", ras_top, 32'hF000);
        idle(); ras_pop = 1'b1; step("pop_f");
        chk("pushpop_count", {31'b0, ras_valid}, 32'h0);
        idle(); ras_push = 1'b1; ras_pop = 1'b1; ras_push_addr = 32'hC000; step("pushpop_empty");
        idle(); exc_valid = 1'b1; ras_push = 1'b1; ras_push_addr = 32'hD000; exc_pc = 32'h123;
        step("exc_clear");
        chk("exc_clear_valid", {31'b0, ras_valid}, 32'h0);

        idle();
        reset8 = 1'b1; step("w8_reset");
        reset8 = 1'b0; redirect_valid8 = 1'b1; redirect_target8 = 8'hFC;
        ras_push8 = 1'b1; ras_push_addr8 = 8'h55;
        step("w8_fc");
        chk("w8_pc_fc", {24'b0, pc_out8}, 32'hFC);
        chk("w8_push_valid", {24'b0, 7'b0, ras_valid8}, 32'h1);
        redirect_valid8 = 1'b0; ras_push8 = 1'b0;
        step("w8_wrap");
        chk("w8_pc_wrap", {24'b0, pc_out8}, 32'h00);
        chk("w8_top", {24'b0, ras_top8}, 32'h55);
        redirect_valid8 = 1'b1; redirect_target8 = 8'h40;
        step("w8_move");
        redirect_valid8 = 1'b0; reset8 = 1'b1; ras_push8 = 1'b1; ras_push_addr8 = 8'h77;
        step("w8_rst_push");
        chk("w8_rst_pc", {24'b0, pc_out8}, 32'h00);
        chk("w8_rst_valid", {24'b0, 7'b0, ras_valid8}, 32'h0);
        chk("w8_rst_top", {24'b0, ras_top8}, 32'h0);
        reset8 = 1'b0; ras_push8 = 1'b0;
        step("w8_after");
        chk("w8_after_pc", {24'b0, pc_out8}, 32'h04);

        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 63) == 0);
            exc_valid      = ($urandom_range(0, 15) == 0);
            eret           = ($urandom_range(0, 11) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            stall          = ($urandom_range(0, 3) == 0);
            ras_push       = ($urandom_range(0, 2) == 0);
            ras_pop        = ($urandom_range(0, 2) == 0);
            redirect_target = $urandom;
            exc_pc          = $urandom;
            ras_push_addr   = $urandom;
            if ($urandom_range(0, 1) == 0) redirect_target[1:0] = 2'b00;
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
